// File: rtl/watch_pkg.sv
// Shared mode encodings, field limits and decimal-point masks for the watch core.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_SEC  = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_HOUR = 2'd3
  } mode_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  localparam logic [5:0] DP_NONE = 6'b000000;
  localparam logic [5:0] DP_SEC  = 6'b000011;
  localparam logic [5:0] DP_MIN  = 6'b001100;
  localparam logic [5:0] DP_HOUR = 6'b110000;

  function automatic logic [5:0] dp_for(input mode_e m);
    logic [5:0] dp;
    dp = DP_NONE;
    unique case (m)
      MODE_RUN:      dp = DP_NONE;
      MODE_SET_SEC:  dp = DP_SEC;
      MODE_SET_MIN:  dp = DP_MIN;
      MODE_SET_HOUR: dp = DP_HOUR;
    endcase
    return dp;
  endfunction

endpackage

// File: rtl/hms_watch_core_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce (WATCH_DEBOUNCE_EN),
// registered single-cycle rising-edge press pulse.
module btn_cond #(
  parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic press_q;
  logic press_d;
  logic level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef WATCH_DEBOUNCE_EN
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;
  logic        db_q;
  logic        db_d;

  // Counter runs only while the synchronized level disagrees; any agreement restarts it.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q + 20'd1 >= DB_CYCLES) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign level = db_q;
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  assign level     = sync2_q;
`endif

  always_comb begin
    press_d = level & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= level;
      press_q <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/hms_watch_core.sv
// Hours/minutes/seconds time-keeping core with button-driven set mode.
// Optional button debounce enabled by defining WATCH_DEBOUNCE_EN.
module hms_watch_core
  import watch_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic [5:0] o_edit_dp
);

  logic mode_press;
  logic up_press;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_mode),
    .o_press (mode_press)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_btn_up),
    .o_press (up_press)
  );

  mode_e      state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] dp_q, dp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE_RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      dp_q    <= DP_NONE;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      dp_q    <= dp_d;
    end
  end

  // Mode press takes priority over an up press; ticks only count in RUN.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    unique case (state_q)
      MODE_RUN: begin
        if (i_tick) begin
          if (sec_q >= SEC_MAX) begin
            sec_d = '0;
            if (min_q >= MIN_MAX) begin
              min_d  = '0;
              hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_press) state_d = MODE_SET_SEC;
      end
      MODE_SET_SEC: begin
        if (mode_press)    state_d = MODE_SET_MIN;
        else if (up_press) sec_d = (sec_q >= SEC_MAX) ? '0 : sec_q + 6'd1;
      end
      MODE_SET_MIN: begin
        if (mode_press)    state_d = MODE_SET_HOUR;
        else if (up_press) min_d = (min_q >= MIN_MAX) ? '0 : min_q + 6'd1;
      end
      MODE_SET_HOUR: begin
        if (mode_press)    state_d = MODE_RUN;
        else if (up_press) hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + 5'd1;
      end
    endcase
    dp_d = dp_for(state_d);
  end

  assign o_sec     = sec_q;
  assign o_min     = min_q;
  assign o_hour    = hour_q;
  assign o_mode    = state_q;
  assign o_edit_dp = dp_q;

endmodule

// File: tb/tb_hms_watch_core.sv
// Randomized self-checking bench for hms_watch_core against a seconds-of-day reference model.
module tb_hms_watch_core;

`ifdef WATCH_DEBOUNCE_EN
  localparam int unsigned LAT = 12;
`else
  localparam int unsigned LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic [5:0] edit_dp;

  int total = 0;
  int bad = 0;

  int m_s = 0;
  int m_m = 0;
  int m_h = 0;
  int m_mode = 0;

  hms_watch_core #(.DB_CYCLES(20'd8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tick     (tick),
    .i_btn_mode (btn_mode),
    .i_btn_up   (btn_up),
    .o_sec      (sec),
    .o_min      (min),
    .o_hour     (hour),
    .o_mode     (mode),
    .o_edit_dp  (edit_dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_dp(input int md);
    case (md)
      1:       return 6'b000011;
      2:       return 6'b001100;
      3:       return 6'b110000;
      default: return 0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".sec"},  32'(sec),     m_s);
    chk({tag, ".min"},  32'(min),     m_m);
    chk({tag, ".hour"}, 32'(hour),    m_h);
    chk({tag, ".mode"}, 32'(mode),    m_mode);
    chk({tag, ".dp"},   32'(edit_dp), exp_dp(m_mode));
  endtask

  function automatic void m_tick();
    int t;
    if (m_mode == 0) begin
      t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = t / 3600;
      m_m = (t / 60) % 60;
      m_s = t % 60;
    end
  endfunction

  function automatic void m_up();
    case (m_mode)
      1: m_s = (m_s + 1) % 60;
      2: m_m = (m_m + 1) % 60;
      3: m_h = (m_h + 1) % 24;
      default: ;
    endcase
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    m_tick();
  endtask

  // Raise the selected buttons; optionally coincide a tick with the cycle the press lands.
  task automatic do_press(input logic m, input logic u, input logic tk, input int unsigned hold_extra);
    btn_mode = m;
    btn_up   = u;
    cyc(LAT - 1);
    check_all("early");
    tick = tk;
    cyc(1);
    tick = 1'b0;
    if (tk) m_tick();
    if (m) m_mode = (m_mode + 1) % 4;
    else if (u) m_up();
    check_all("press");
    cyc(hold_extra);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    cyc(LAT + 2);
    check_all("release");
  endtask

  task automatic ups(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) do_press(1'b0, 1'b1, 1'b0, $urandom_range(0, 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_s = 0; m_m = 0; m_h = 0; m_mode = 0;
    #1;
    check_all("reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    #1;
    check_all("por");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check_all("after_por");

    for (int unsigned i = 0; i < 61; i++) do_tick();
    check_all("ticks61");

    do_reset();
    do_press(1'b1, 1'b0, 1'b0, 1);
    ups(59);
    do_press(1'b1, 1'b0, 1'b0, 1);
    ups(59);
    do_press(1'b1, 1'b0, 1'b0, 1);
    ups(23);
    do_press(1'b1, 1'b0, 1'b0, 1);
    check_all("set_235959");
    do_tick();
    check_all("wrap_day");

    do_reset();
    do_press(1'b1, 1'b0, 1'b0, 0);
    for (int unsigned i = 0; i < 10; i++) do_tick();
    check_all("frozen");
    ups(60);
    check_all("sec_wrap60");
    ups(1);
    check_all("sec_61");

    do_press(1'b1, 1'b0, 1'b0, 0);
    ups(3);
    do_press(1'b1, 1'b1, 1'b0, 2);
    check_all("mode_beats_up");
    ups(2);
    do_press(1'b1, 1'b0, 1'b1, 1);
    check_all("sethour_exit_tick");
    do_tick();
    do_press(1'b1, 1'b0, 1'b1, 1);
    check_all("run_mode_tick");
    do_press(1'b1, 1'b0, 1'b0, 0);
    do_press(1'b1, 1'b0, 1'b0, 0);
    do_press(1'b1, 1'b0, 1'b0, 0);

    for (int unsigned it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          int unsigned n;
          n = $urandom_range(1, 150);
          for (int unsigned k = 0; k < n; k++) begin
            do_tick();
            cyc($urandom_range(0, 2));
          end
          check_all("burst");
        end
        1: do_press(1'b0, 1'b1, 1'b0, $urandom_range(0, 4));
        2: do_press(1'b1, 1'b0, 1'b0, $urandom_range(0, 4));
        3: do_press(1'b1, 1'b1, 1'b0, $urandom_range(0, 4));
        4: do_press(1'b1, 1'b0, 1'b1, $urandom_range(0, 4));
        default: do_press(1'b0, 1'b1, 1'b1, $urandom_range(0, 4));
      endcase
    end

    do_reset();
    do_press(1'b1, 1'b0, 1'b0, 0);
    do_press(1'b1, 1'b0, 1'b0, 0);
    do_press(1'b1, 1'b0, 1'b0, 0);
    ups(5);
    check_all("hour5");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_s = 0; m_m = 0; m_h = 0; m_mode = 0;
    #1;
    check_all("async_rst");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check_all("post_rst");

`ifdef WATCH_DEBOUNCE_EN
    do_press(1'b1, 1'b0, 1'b0, 0);
    btn_up = 1'b1;
    cyc(5);
    btn_up = 1'b0;
    cyc(20);
    check_all("db_glitch");
    btn_up = 1'b1;
    cyc(20);
    btn_up = 1'b0;
    cyc(20);
    m_up();
    check_all("db_held");
    btn_up = 1'b1;
    cyc(20);
    m_up();
    btn_up = 1'b0; cyc(3);
    btn_up = 1'b1; cyc(2);
    btn_up = 1'b0; cyc(3);
    btn_up = 1'b1; cyc(2);
    btn_up = 1'b0; cyc(20);
    check_all("db_bouncy");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hms_watch_core.md
Name: hms_watch_core

Overview:
- Time-keeping core: hours/minutes/seconds with a button-driven set mode.
- Sits upstream of the two-digit split / 7-segment decode / 6-digit multiplexed display chain.
- Consumes a 1 Hz single-cycle tick from an NCO-derived strobe.
- Produces three binary fields (sec, min, hour) and a per-digit decimal-point mask that marks the field being edited.

Parameters:
- DB_CYCLES, 20'd1000000, debounce stability window in clk cycles (20 ms at 50 MHz); used only when WATCH_DEBOUNCE_EN is defined.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset, asynchronous, active-low
- i_tick  input  1  one-clk-wide 1 Hz advance strobe, synchronous to clk
- i_btn_mode  input  1  raw mode button level, active-high, asynchronous
- i_btn_up  input  1  raw increment button level, active-high, asynchronous
- o_sec  output  6  seconds 0..59
- o_min  output  6  minutes 0..59
- o_hour  output  5  hours 0..23
- o_mode  output  2  current FSM state: 0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
- o_edit_dp  output  6  active-high dp mask; bit0 = seconds ones digit ... bit5 = hours tens digit

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: o_sec=0, o_min=0, o_hour=0, o_mode=RUN, o_edit_dp=6'b000000. All synchronizer, debounce and edge registers clear to 0.
- Button conditioning (per button):
  - Two-flop synchronizer, then a registered previous-level flop.
  - Press pulse = current & ~previous.
  - Without debounce, the state/field update is visible at the 4th rising clk edge after the raw input rises (2 sync + 1 edge register + 1 update register).
  - Release generates no pulse. A held button generates exactly one pulse.
- FSM on a mode press: RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN.
- RUN:
  - On i_tick: sec+1.
  - sec 59->0 carries min+1; min 59->0 carries hour+1; hour 23->0. All carries resolve in the same cycle.
  - Up presses are ignored.
- SET_SEC / SET_MIN / SET_HOUR:
  - i_tick is ignored; time is frozen.
  - Up press increments only the selected field, wrapping at its maximum (59, 59, 23) to 0, with no carry into other fields.
- o_edit_dp by state: RUN 000000; SET_SEC 000011; SET_MIN 001100; SET_HOUR 110000.
- o_edit_dp and o_mode are registered and change in the same cycle.
- Simultaneous events:
  - Mode press and up press in the same cycle: mode wins; the up press is discarded.
  - Mode press and i_tick in RUN in the same cycle: the tick is applied (including carries) and the state moves to SET_SEC.
  - SET_HOUR -> RUN transition and i_tick in the same cycle: the tick is ignored; counting resumes at the next tick.
- Width/range: fields never hold out-of-range values. The comparison uses ">= max" for wrap, so corrupted values also recover to 0.
- Reset mid-operation: immediate asynchronous return to all-zero RUN. Pending press pulses are lost.

Optional Feature:
- Macro: WATCH_DEBOUNCE_EN.
- Defined:
  - Each synchronized button feeds a 20-bit stability counter.
  - The debounced level updates only after the synchronized level differs from it for DB_CYCLES consecutive cycles. Any bounce restarts the counter at 0.
  - Edge detection operates on the debounced level.
  - Added latency: DB_CYCLES cycles.
- Undefined: no counter; edge detection operates directly on the synchronizer output. DB_CYCLES is unused.

Decomposition:
- Package watch_pkg:
  - Mode encodings MODE_RUN/MODE_SET_SEC/MODE_SET_MIN/MODE_SET_HOUR (2-bit).
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - DP masks DP_NONE, DP_SEC, DP_MIN, DP_HOUR (6-bit).
- Sub-module btn_cond:
  - Synchronizer + optional debounce + rising-edge pulse.
  - Parameter DB_CYCLES; ports clk, rst_n, i_btn, o_press.
  - Instantiated twice.
- Time counters and FSM stay in hms_watch_core.

Test Plan:
- Reset, then 61 i_tick pulses -> o_sec=1, o_min=1, o_hour=0, o_mode=0.
- Set 23:59:59 via set mode (up presses: 23 hour, 59 min, 59 sec), return to RUN, one tick -> 00:00:00.
- Reset, one mode press -> o_mode=1, o_edit_dp=000011. Then 10 ticks -> o_sec stays 0. Then 60 up presses -> o_sec=0 with o_min unchanged; 61 presses total -> o_sec=1.
- In SET_MIN, mode and up pulses rising in the same cycle -> o_mode=3, o_edit_dp=110000, o_min unchanged.
- In SET_HOUR with hour=5, assert rst_n=0 mid-cycle -> outputs 0 and o_mode=0 immediately, without waiting for a clk edge.
- WATCH_DEBOUNCE_EN with DB_CYCLES=8:
  - 5-cycle glitch on i_btn_up in SET_SEC -> no increment.
  - Level held 20 cycles -> exactly one increment.
  - Bouncy release -> no increment.
